// File: rtl/uart_word_bridge_if.sv
// Word-stream bundle for uart_word_bridge: TX words in (s_word_*), RX words out (m_word_*).
// master = bridge side, slave = host side.
interface uart_word_bridge_if #(
  parameter int WORD_BYTES = 4,
  parameter int DATA_WIDTH = 8
);
  logic [WORD_BYTES*DATA_WIDTH-1:0] s_word_data;
  logic                             s_word_valid;
  logic                             s_word_ready;
  logic [WORD_BYTES*DATA_WIDTH-1:0] m_word_data;
  logic                             m_word_valid;
  logic                             m_word_ready;

  modport master (
    input  s_word_data,
    input  s_word_valid,
    output s_word_ready,
    output m_word_data,
    output m_word_valid,
    input  m_word_ready
  );

  modport slave (
    output s_word_data,
    output s_word_valid,
    input  s_word_ready,
    input  m_word_data,
    input  m_word_valid,
    output m_word_ready
  );
endinterface

// File: rtl/uart_word_bridge.sv
// Word<->byte bridge to a byte UART FIFO port; TX 3 cycles/byte with a forced drain once the FIFO budget is spent,
// RX 3 cycles/byte, last byte left in the UART FIFO while the assembled word is stalled on m_word_ready.
module uart_word_bridge #(
  parameter int WORD_BYTES = 4,
  parameter int DATA_WIDTH = 8,
  parameter int FIFO_SLOTS = 31,
  parameter int RX_TIMEOUT = 100000,
  parameter int BIG_ENDIAN = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  uart_word_bridge_if.master    word,
  output logic [DATA_WIDTH-1:0] uart_data_in,
  output logic                  uart_tx_use,
  input  logic                  uart_tx_complete,
  input  logic                  uart_rx_flag,
  input  logic [DATA_WIDTH-1:0] uart_data_out,
  output logic                  uart_rx_use,
  output logic                  tx_busy,
  output logic                  rx_timeout_err
);

  localparam int WW = WORD_BYTES * DATA_WIDTH;
  localparam int IW = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam int SW = $clog2(FIFO_SLOTS + 1);
  localparam int TW = $clog2(RX_TIMEOUT + 1);

  localparam logic [IW-1:0] LAST_IDX = IW'(WORD_BYTES - 1);
  localparam logic [SW-1:0] SLOT_MAX = SW'(FIFO_SLOTS);
  localparam logic [TW-1:0] TO_MAX   = TW'(RX_TIMEOUT - 1);
  localparam logic [1:0]    DRAIN_IGNORE = 2'd2;

  // Wire order of bytes: index 0 goes out first, mapped to a lane by endianness.
  function automatic logic [IW-1:0] lane(input logic [IW-1:0] idx);
    return (BIG_ENDIAN != 0) ? (LAST_IDX - idx) : idx;
  endfunction

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_SETUP,
    TX_PULSE,
    TX_GAP,
    TX_DRAIN
  } tx_state_t;

  typedef enum logic [1:0] {
    RX_WAIT,
    RX_POP,
    RX_GAP
  } rx_state_t;

  tx_state_t tx_state;
  tx_state_t tx_next;
  rx_state_t rx_state;
  rx_state_t rx_next;

  logic [WW-1:0]         tx_word;
  logic [IW-1:0]         byte_idx;
  logic [SW-1:0]         slot_cnt;
  logic [1:0]            drain_cnt;
  logic [DATA_WIDTH-1:0] tx_byte;
  logic                  tx_last;

  logic [WW-1:0]         rx_asm;
  logic [IW-1:0]         rx_idx;
  logic [TW-1:0]         to_cnt;
  logic                  rx_last;
  logic                  rx_hold;
  logic                  rx_capture;
  logic                  to_run;
  logic                  to_hit;

  assign tx_byte = tx_word[lane(byte_idx)*DATA_WIDTH +: DATA_WIDTH];
  assign tx_last = (byte_idx == LAST_IDX);

  // ---------------------------------------------------------------- TX
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_state <= TX_IDLE;
    end else begin
      tx_state <= tx_next;
    end
  end

  always_comb begin
    tx_next           = tx_state;
    uart_tx_use       = 1'b0;
    tx_busy           = 1'b1;
    word.s_word_ready = 1'b0;
    case (tx_state)
      TX_IDLE: begin
        tx_busy           = 1'b0;
        word.s_word_ready = 1'b1;
        if (word.s_word_valid) begin
          tx_next = TX_SETUP;
        end
      end
      TX_SETUP: begin
        tx_next = (slot_cnt == SLOT_MAX) ? TX_DRAIN : TX_PULSE;
      end
      TX_PULSE: begin
        uart_tx_use = 1'b1;
        tx_next     = TX_GAP;
      end
      TX_GAP: begin
        tx_next = tx_last ? TX_IDLE : TX_SETUP;
      end
      TX_DRAIN: begin
        // The UART's complete flag lags its FIFO by two cycles after the last push.
        if ((drain_cnt == DRAIN_IGNORE) && uart_tx_complete) begin
          tx_next = TX_SETUP;
        end
      end
      default: begin
        tx_next = TX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_word      <= '0;
      byte_idx     <= '0;
      slot_cnt     <= '0;
      drain_cnt    <= '0;
      uart_data_in <= '0;
    end else begin
      case (tx_state)
        TX_IDLE: begin
          if (word.s_word_valid) begin
            tx_word  <= word.s_word_data;
            byte_idx <= '0;
          end
        end
        TX_SETUP: begin
          if (slot_cnt != SLOT_MAX) begin
            uart_data_in <= tx_byte;
          end
        end
        TX_PULSE: begin
          if (slot_cnt != SLOT_MAX) begin
            slot_cnt <= slot_cnt + 1'b1;
          end
        end
        TX_GAP: begin
          if (!tx_last) begin
            byte_idx <= byte_idx + 1'b1;
          end
        end
        TX_DRAIN: begin
          if (drain_cnt != DRAIN_IGNORE) begin
            drain_cnt <= drain_cnt + 1'b1;
          end else if (uart_tx_complete) begin
            drain_cnt <= '0;
            slot_cnt  <= '0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // ---------------------------------------------------------------- RX
  assign rx_last = (rx_idx == LAST_IDX);
  // Leave the closing byte in the UART FIFO until the previous word is taken.
  assign rx_hold = rx_last && word.m_word_valid && !word.m_word_ready;
  assign to_run  = (rx_state == RX_WAIT) && (rx_idx != '0);
  assign to_hit  = to_run && !rx_capture && (to_cnt == TO_MAX);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_state <= RX_WAIT;
    end else begin
      rx_state <= rx_next;
    end
  end

  always_comb begin
    rx_next     = rx_state;
    uart_rx_use = 1'b0;
    rx_capture  = 1'b0;
    case (rx_state)
      RX_WAIT: begin
        if (uart_rx_flag && !rx_hold) begin
          rx_capture = 1'b1;
          rx_next    = RX_POP;
        end
      end
      RX_POP: begin
        uart_rx_use = 1'b1;
        rx_next     = RX_GAP;
      end
      RX_GAP: begin
        rx_next = RX_WAIT;
      end
      default: begin
        rx_next = RX_WAIT;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_asm            <= '0;
      rx_idx            <= '0;
      to_cnt            <= '0;
      rx_timeout_err    <= 1'b0;
      word.m_word_data  <= '0;
      word.m_word_valid <= 1'b0;
    end else begin
      rx_timeout_err <= to_hit;

      if (!to_run || rx_capture || to_hit) begin
        to_cnt <= '0;
      end else begin
        to_cnt <= to_cnt + 1'b1;
      end

      if (rx_capture) begin
        rx_asm[lane(rx_idx)*DATA_WIDTH +: DATA_WIDTH] <= uart_data_out;
      end else if (to_hit) begin
        rx_asm <= '0;
        rx_idx <= '0;
      end

      if (rx_state == RX_GAP) begin
        if (rx_last) begin
          word.m_word_data <= rx_asm;
          rx_idx           <= '0;
        end else begin
          rx_idx <= rx_idx + 1'b1;
        end
      end

      // A commit in the same cycle as an accept keeps valid high with fresh data.
      if ((rx_state == RX_GAP) && rx_last) begin
        word.m_word_valid <= 1'b1;
      end else if (word.m_word_valid && word.m_word_ready) begin
        word.m_word_valid <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_uart_word_bridge.sv
// Directed bench for uart_word_bridge: TX byte order/timing, FIFO drain, RX assembly, backpressure, timeout, reset.
module tb_uart_word_bridge;

  localparam int RXT = 40;

  logic       clk;
  logic       rst_n;
  logic [7:0] uart_data_in;
  logic       uart_tx_use;
  logic       uart_tx_complete;
  logic       uart_rx_flag;
  logic [7:0] uart_data_out;
  logic       uart_rx_use;
  logic       tx_busy;
  logic       rx_timeout_err;

  int errors     = 0;
  int checks     = 0;
  int rx_pops    = 0;
  int err_pulses = 0;

  uart_word_bridge_if #(.WORD_BYTES(4), .DATA_WIDTH(8)) wif ();

  uart_word_bridge #(
    .WORD_BYTES(4),
    .DATA_WIDTH(8),
    .FIFO_SLOTS(31),
    .RX_TIMEOUT(RXT),
    .BIG_ENDIAN(0)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .word             (wif),
    .uart_data_in     (uart_data_in),
    .uart_tx_use      (uart_tx_use),
    .uart_tx_complete (uart_tx_complete),
    .uart_rx_flag     (uart_rx_flag),
    .uart_data_out    (uart_data_out),
    .uart_rx_use      (uart_rx_use),
    .tx_busy          (tx_busy),
    .rx_timeout_err   (rx_timeout_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (uart_rx_use === 1'b1) rx_pops++;
    if (rx_timeout_err === 1'b1) err_pulses++;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, errors=%0d", errors);
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] word_of(input int i);
    logic [31:0] w;
    logic [7:0]  b;
    w = '0;
    for (int j = 0; j < 4; j++) begin
      b = 8'(4 * i + j + 1);
      w[8*j +: 8] = b;
    end
    return w;
  endfunction

  task automatic do_reset();
    rst_n            = 1'b0;
    wif.s_word_valid = 1'b0;
    wif.m_word_ready = 1'b0;
    uart_rx_flag     = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic wait_rx_pop(input string tag);
    int n = 0;
    while (uart_rx_use !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, uart_rx_use}, 32'd1);
  endtask

  task automatic send_byte(input logic [7:0] b);
    uart_rx_flag  = 1'b1;
    uart_data_out = b;
    @(negedge clk);
    wait_rx_pop($sformatf("rx_pop_%02h", b));
    uart_rx_flag = 1'b0;
  endtask

  task automatic wait_m_valid(input string tag);
    int n = 0;
    while (wif.m_word_valid !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    chk(tag, {31'd0, wif.m_word_valid}, 32'd1);
  endtask

  task automatic accept_word();
    wif.m_word_ready = 1'b1;
    @(negedge clk);
    wif.m_word_ready = 1'b0;
  endtask

  // Streams word_of(0..nwords-1); counts pushes, gap between the last two, last byte.
  task automatic tx_stream(input int nwords, input int ncycles, output int npulse,
                           output int last_gap, output logic [7:0] last_byte, output int accepted);
    int  last_pulse = -1;
    bit  go = 0;
    npulse    = 0;
    last_gap  = 0;
    last_byte = '0;
    accepted  = 0;
    wif.s_word_valid = 1'b1;
    wif.s_word_data  = word_of(0);
    go = (wif.s_word_ready === 1'b1);
    for (int c = 0; c < ncycles; c++) begin
      @(negedge clk);
      if (uart_tx_use === 1'b1) begin
        npulse++;
        if (last_pulse >= 0) last_gap = c - last_pulse;
        last_pulse = c;
        last_byte  = uart_data_in;
      end
      if (go) accepted++;
      wif.s_word_valid = (accepted < nwords);
      wif.s_word_data  = word_of(accepted);
      go = wif.s_word_valid && (wif.s_word_ready === 1'b1);
    end
    wif.s_word_valid = 1'b0;
  endtask

  int          np;
  int          gap;
  int          acc;
  int          n;
  int          base;
  logic [7:0]  lb;
  logic [31:0] tx_w;
  logic        exp_pulse;

  initial begin
    rst_n            = 1'b0;
    wif.s_word_valid = 1'b0;
    wif.s_word_data  = '0;
    wif.m_word_ready = 1'b0;
    uart_tx_complete = 1'b0;
    uart_rx_flag     = 1'b0;
    uart_data_out    = '0;

    // Reset values
    @(negedge clk);
    chk("rst_tx_use",       {31'd0, uart_tx_use},      32'd0);
    chk("rst_rx_use",       {31'd0, uart_rx_use},      32'd0);
    chk("rst_data_in",      {24'd0, uart_data_in},     32'd0);
    chk("rst_m_word_data",  wif.m_word_data,           32'd0);
    chk("rst_m_word_valid", {31'd0, wif.m_word_valid}, 32'd0);
    chk("rst_timeout_err",  {31'd0, rx_timeout_err},   32'd0);
    chk("rst_tx_busy",      {31'd0, tx_busy},          32'd0);
    chk("rst_s_word_ready", {31'd0, wif.s_word_ready}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // TX byte order and cycle timing
    tx_w = 32'h4433_2211;
    wif.s_word_data  = tx_w;
    wif.s_word_valid = 1'b1;
    chk("tx_ready_c0", {31'd0, wif.s_word_ready}, 32'd1);
    for (int k = 1; k <= 14; k++) begin
      @(negedge clk);
      if (k == 1) wif.s_word_valid = 1'b0;
      exp_pulse = (k % 3 == 2) && (k <= 11);
      chk($sformatf("tx_use_c%0d", k), {31'd0, uart_tx_use}, {31'd0, exp_pulse});
      if (exp_pulse)
        chk($sformatf("tx_byte_c%0d", k), {24'd0, uart_data_in}, (tx_w >> (8 * ((k - 2) / 3))) & 32'hFF);
      chk($sformatf("tx_ready_c%0d", k), {31'd0, wif.s_word_ready}, {31'd0, k >= 13});
    end

    // TX drain: complete held low
    do_reset();
    uart_tx_complete = 1'b0;
    tx_stream(8, 200, np, gap, lb, acc);
    chk("drain_pulses",    np,                            32'd31);
    chk("drain_accepted",  acc,                           32'd8);
    chk("drain_busy",      {31'd0, tx_busy},              32'd1);
    chk("drain_ready",     {31'd0, wif.s_word_ready},     32'd0);
    chk("drain_last_byte", {24'd0, lb},                   32'h1F);
    uart_tx_complete = 1'b1;
    n = 0;
    while (uart_tx_use !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("drain_exit_latency", n,                     32'd2);
    chk("drain_32nd_byte",    {24'd0, uart_data_in}, 32'h20);
    repeat (3) @(negedge clk);
    chk("drain_ready_after",  {31'd0, wif.s_word_ready}, 32'd1);

    // TX drain: complete already high, the two-cycle ignore window still applies
    do_reset();
    uart_tx_complete = 1'b1;
    tx_stream(8, 200, np, gap, lb, acc);
    chk("drain2_pulses",    np,           32'd32);
    chk("drain2_gap",       gap,          32'd7);
    chk("drain2_last_byte", {24'd0, lb},  32'h20);

    // Reset during TX_PULSE
    do_reset();
    uart_tx_complete = 1'b0;
    wif.s_word_data  = 32'hCAFE_F00D;
    wif.s_word_valid = 1'b1;
    n = 0;
    @(negedge clk);
    wif.s_word_valid = 1'b0;
    while (uart_tx_use !== 1'b1 && n < 10) begin
      @(negedge clk);
      n++;
    end
    chk("rstmid_reached_pulse", {31'd0, uart_tx_use}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("rstmid_tx_use", {31'd0, uart_tx_use},      32'd0);
    chk("rstmid_busy",   {31'd0, tx_busy},          32'd0);
    chk("rstmid_ready",  {31'd0, wif.s_word_ready}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("rstmid_slot_cnt",    {27'd0, dut.slot_cnt},     32'd0);
    chk("rstmid_ready_after", {31'd0, wif.s_word_ready}, 32'd1);

    // RX assembly
    wif.m_word_ready = 1'b0;
    base = rx_pops;
    send_byte(8'hAA);
    send_byte(8'hBB);
    send_byte(8'hCC);
    send_byte(8'hDD);
    wait_m_valid("rx_valid_1");
    chk("rx_word_1", wif.m_word_data, 32'hDDCC_BBAA);
    chk("rx_pops_1", rx_pops - base,  32'd4);
    accept_word();
    chk("rx_valid_cleared", {31'd0, wif.m_word_valid}, 32'd0);

    // RX backpressure: last byte of the second word stays in the UART FIFO
    base = rx_pops;
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    send_byte(8'h66);
    send_byte(8'h77);
    uart_rx_flag  = 1'b1;
    uart_data_out = 8'h88;
    repeat (10) @(negedge clk);
    chk("bp_pops_held",  rx_pops - base,                32'd7);
    chk("bp_valid_held", {31'd0, wif.m_word_valid},     32'd1);
    chk("bp_word_1",     wif.m_word_data,               32'h4433_2211);
    accept_word();
    chk("bp_accepted",   {31'd0, wif.m_word_valid},     32'd0);
    wait_rx_pop("bp_pop_8th");
    uart_rx_flag = 1'b0;
    wait_m_valid("bp_valid_2");
    chk("bp_word_2",     wif.m_word_data,               32'h8877_6655);
    chk("bp_pops_all",   rx_pops - base,                32'd8);
    accept_word();

    // RX timeout on a partial word
    base = err_pulses;
    send_byte(8'h01);
    send_byte(8'h02);
    for (int k = 1; k <= 43; k++) begin
      @(negedge clk);
      if (k == 41) chk("to_err_before", {31'd0, rx_timeout_err}, 32'd0);
      if (k == 42) chk("to_err_pulse",  {31'd0, rx_timeout_err}, 32'd1);
      if (k == 43) chk("to_err_after",  {31'd0, rx_timeout_err}, 32'd0);
    end
    chk("to_err_count", err_pulses - base, 32'd1);
    chk("to_no_word",   {31'd0, wif.m_word_valid}, 32'd0);
    send_byte(8'hA1);
    send_byte(8'hB2);
    send_byte(8'hC3);
    send_byte(8'hD4);
    wait_m_valid("to_valid_clean");
    chk("to_clean_word", wif.m_word_data, 32'hD4C3_B2A1);
    accept_word();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
